// File: rtl/cpu_writeback_pkg.sv
// Shared types and constants for the writeback stage.
// Holds the memory/writeback bundles, register-file widths and FSM encoding.
package cpu_writeback_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RETIRE_W   = 64;

    localparam logic [REG_ADDR_W-1:0] X0_INDEX = '0;

    typedef struct packed {
        logic [XLEN-1:0]       rd;
        logic [REG_ADDR_W-1:0] inst_rd;
        logic                  strobe;
    } memory_data_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] inst_rd;
        logic [XLEN-1:0]       rd;
        logic                  strobe;
    } writeback_data_t;

    // One-hot so a corrupted state is detectable and recoverable.
    typedef enum logic [1:0] {
        WB_CLEAR = 2'b01,
        WB_RUN   = 2'b10
    } wb_state_t;

    // Index names a real, writable register (not x0, not past RV32E top).
    function automatic logic reg_writable(
        input logic [REG_ADDR_W-1:0] idx,
        input int                    count
    );
        return (idx != X0_INDEX) && (int'(idx) < count);
    endfunction

endpackage

// File: rtl/cpu_writeback_registers.sv
// Architectural register array: one sync write port, two async read ports.
// Reads forward the in-flight commit value so decode sees it the same cycle.
module cpu_writeback_registers
    import cpu_writeback_pkg::*;
#(
    parameter int REGISTER_COUNT = 32
) (
    input  logic                  i_clock,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]       i_wdata,
    input  logic                  i_bypass_en,
    input  logic                  i_read_en,
    input  logic [REG_ADDR_W-1:0] i_rs1_index,
    output logic [XLEN-1:0]       o_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2_index,
    output logic [XLEN-1:0]       o_rs2
);

    localparam int IW = $clog2(REGISTER_COUNT);

    logic [XLEN-1:0] r_regs [REGISTER_COUNT];

    // Single write port shared by the clear sweep and commits.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            r_regs[i_waddr[IW-1:0]] <= i_wdata;
        end
    end

    function automatic logic [XLEN-1:0] read_port(
        input logic [REG_ADDR_W-1:0] idx
    );
        logic [XLEN-1:0] v;
        v = '0;
        if (i_read_en && reg_writable(idx, REGISTER_COUNT)) begin
            if (i_bypass_en && (i_waddr == idx)) begin
                v = i_wdata;
            end else begin
                v = r_regs[idx[IW-1:0]];
            end
        end
        return v;
    endfunction

    // Port 1 read with same-cycle commit forwarding.
    always_comb begin
        o_rs1 = read_port(i_rs1_index);
    end

    // Port 2 read with same-cycle commit forwarding.
    always_comb begin
        o_rs2 = read_port(i_rs2_index);
    end

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage: clears the register file after reset, then commits
// memory-stage results via strobe toggles and counts retired instructions.
module cpu_writeback
    import cpu_writeback_pkg::*;
#(
    parameter int REGISTER_COUNT = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  memory_data_t          i_data,
    output logic                  o_busy,
    output logic                  o_ready,
    input  logic [REG_ADDR_W-1:0] i_rs1_index,
    output logic [XLEN-1:0]       o_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2_index,
    output logic [XLEN-1:0]       o_rs2,
    output writeback_data_t       o_data,
    output logic [RETIRE_W-1:0]   o_retired
);

    localparam logic [REG_ADDR_W-1:0] LAST_INDEX =
        REG_ADDR_W'(REGISTER_COUNT - 1);

    wb_state_t             r_state;
    wb_state_t             w_next_state;
    logic [REG_ADDR_W-1:0] r_clear_index;
    logic [REG_ADDR_W-1:0] w_next_clear_index;
    logic                  r_last_strobe;
    writeback_data_t       r_data;
    logic [RETIRE_W-1:0]   r_retired;

    logic                  w_running;
    logic                  w_accept;
    logic                  w_commit_write;
    logic                  w_clear_write;
    logic                  w_rf_we;
    logic [REG_ADDR_W-1:0] w_rf_waddr;
    logic [XLEN-1:0]       w_rf_wdata;

    assign w_running = (r_state == WB_RUN);

    // Reset suppresses any commit that would land on the same edge.
    assign w_accept = !i_reset && w_running &&
                      (i_data.strobe != r_last_strobe);

    assign w_commit_write = w_accept &&
                            reg_writable(i_data.inst_rd, REGISTER_COUNT);

    assign w_clear_write = !i_reset && (r_state == WB_CLEAR);

    assign w_rf_we    = w_clear_write || w_commit_write;
    assign w_rf_waddr = w_clear_write ? r_clear_index : i_data.inst_rd;
    assign w_rf_wdata = w_clear_write ? '0 : i_data.rd;

    assign o_busy    = !w_running;
    assign o_ready   = w_running;
    assign o_data    = r_data;
    assign o_retired = r_retired;

    // State and sweep index registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= WB_CLEAR;
            r_clear_index <= '0;
        end else begin
            r_state       <= w_next_state;
            r_clear_index <= w_next_clear_index;
        end
    end

    // Sweep one entry per cycle, then hold RUN until the next reset.
    always_comb begin
        w_next_state       = r_state;
        w_next_clear_index = r_clear_index;
        unique case (r_state)
            WB_CLEAR: begin
                w_next_clear_index = r_clear_index + 1'b1;
                if (r_clear_index == LAST_INDEX) begin
                    w_next_state = WB_RUN;
                end
            end
            WB_RUN: begin
                w_next_state = WB_RUN;
            end
            default: begin
                w_next_state       = WB_CLEAR;
                w_next_clear_index = '0;
            end
        endcase
    end

    // Commit bookkeeping: handshake edge, last-commit bundle, retire count.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_strobe <= 1'b0;
            r_data        <= '0;
            r_retired     <= '0;
        end else if (w_accept) begin
            r_last_strobe  <= i_data.strobe;
            r_data.inst_rd <= i_data.inst_rd;
            r_data.rd      <= i_data.rd;
            r_data.strobe  <= ~r_data.strobe;
            r_retired      <= r_retired + 1'b1;
        end
    end

    cpu_writeback_registers #(
        .REGISTER_COUNT(REGISTER_COUNT)
    ) u_registers (
        .i_clock     (i_clock),
        .i_we        (w_rf_we),
        .i_waddr     (w_rf_waddr),
        .i_wdata     (w_rf_wdata),
        .i_bypass_en (w_commit_write),
        .i_read_en   (w_running),
        .i_rs1_index (i_rs1_index),
        .o_rs1       (o_rs1),
        .i_rs2_index (i_rs2_index),
        .o_rs2       (o_rs2)
    );

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: reference model checked every cycle plus
// directed commits, bypass, sweep and reset-race scenarios.
module tb_cpu_writeback;
    import cpu_writeback_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    memory_data_t    din;
    logic [4:0]      rs1i;
    logic [4:0]      rs2i;
    logic            busy;
    logic            ready;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    writeback_data_t dout;
    logic [63:0]     retired;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_writeback #(.REGISTER_COUNT(32)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_data      (din),
        .o_busy      (busy),
        .o_ready     (ready),
        .i_rs1_index (rs1i),
        .o_rs1       (rs1),
        .i_rs2_index (rs2i),
        .o_rs2       (rs2),
        .o_data      (dout),
        .o_retired   (retired)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: registers, commit record and count after reset.
    logic [31:0]     m_regs [32];
    int              m_since;
    logic            m_last;
    writeback_data_t m_data;
    logic [63:0]     m_ret;
    bit              m_valid = 1'b0;

    function automatic bit m_ready();
        return m_since >= 32;
    endfunction

    function automatic bit m_accept();
        return m_ready() && (din.strobe != m_last);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (!m_ready() || idx == 5'd0) return 32'd0;
        if (m_accept() && din.inst_rd == idx) return din.rd;
        return m_regs[idx];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_since = 0;
            m_last  = 1'b0;
            m_data  = '0;
            m_ret   = 64'd0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else if (m_valid) begin
            if (m_accept()) begin
                m_last = din.strobe;
                if (din.inst_rd != 5'd0) m_regs[din.inst_rd] = din.rd;
                m_data.inst_rd = din.inst_rd;
                m_data.rd      = din.rd;
                m_data.strobe  = ~m_data.strobe;
                m_ret          = m_ret + 64'd1;
            end
            if (m_since < 32) m_since++;
        end
    end

    always @(negedge clk) begin
        if (m_valid && !rst) begin
            check("m_busy", 64'(busy), 64'(!m_ready()));
            check("m_ready", 64'(ready), 64'(m_ready()));
            check("m_data", 64'(dout), 64'(m_data));
            check("m_retired", retired, m_ret);
            check("m_rs1", 64'(rs1), 64'(m_read(rs1i)));
            check("m_rs2", 64'(rs2), 64'(m_read(rs2i)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] v);
        din.inst_rd = r;
        din.rd      = v;
        din.strobe  = ~din.strobe;
        step();
    endtask

    initial begin
        rst  = 1'b1;
        din  = '0;
        rs1i = 5'd0;
        rs2i = 5'd0;
        step();
        rst = 1'b0;

        // Reset state and sweep length.
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_data", 64'(dout), 64'd0);
        check("rst_retired", retired, 64'd0);
        for (int i = 0; i < 31; i++) step();
        check("sweep31_ready", 64'(ready), 64'd0);
        step();
        check("sweep32_ready", 64'(ready), 64'd1);
        check("sweep32_busy", 64'(busy), 64'd0);

        // Basic commit.
        rs1i = 5'd5;
        commit(5'd5, 32'hDEADBEEF);
        check("basic_rs1", 64'(rs1), 64'hDEADBEEF);
        check("basic_strobe", 64'(dout.strobe), 64'd1);
        check("basic_ird", 64'(dout.inst_rd), 64'd5);
        check("basic_retired", retired, 64'd1);

        // x0 commit.
        rs1i = 5'd0;
        commit(5'd0, 32'h12345678);
        check("x0_rs1", 64'(rs1), 64'd0);
        check("x0_strobe", 64'(dout.strobe), 64'd0);
        check("x0_rd", 64'(dout.rd), 64'h12345678);
        check("x0_retired", retired, 64'd2);

        // Bypass in the accept cycle.
        commit(5'd8, 32'h88);
        din.inst_rd = 5'd7;
        din.rd      = 32'hA5A5A5A5;
        din.strobe  = ~din.strobe;
        rs1i = 5'd8;
        rs2i = 5'd7;
        #1;
        check("byp_rs2", 64'(rs2), 64'hA5A5A5A5);
        check("byp_rs1_old", 64'(rs1), 64'h88);
        step();
        check("byp_rs2_array", 64'(rs2), 64'hA5A5A5A5);
        check("byp_retired", retired, 64'd4);

        // Back-to-back commits.
        for (int k = 1; k <= 4; k++) commit(5'(k), 32'(k));
        check("b2b_retired", retired, 64'd8);
        check("b2b_strobe", 64'(dout.strobe), 64'd0);
        check("b2b_ird", 64'(dout.inst_rd), 64'd4);
        rs1i = 5'd1;
        rs2i = 5'd2;
        #1;
        check("b2b_x1", 64'(rs1), 64'd1);
        check("b2b_x2", 64'(rs2), 64'd2);
        rs1i = 5'd3;
        rs2i = 5'd4;
        #1;
        check("b2b_x3", 64'(rs1), 64'd3);
        check("b2b_x4", 64'(rs2), 64'd4);

        // Top register.
        rs1i = 5'd31;
        commit(5'd31, 32'hFFFF0001);
        check("x31_rs1", 64'(rs1), 64'hFFFF0001);
        check("x31_retired", retired, 64'd9);

        // Strobe toggled while sweeping.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_retired", retired, 64'd0);
        check("rst2_data", 64'(dout), 64'd0);
        step();
        step();
        din.inst_rd = 5'd9;
        din.rd      = 32'h55;
        din.strobe  = 1'b1;
        rs1i = 5'd9;
        for (int i = 0; i < 29; i++) step();
        check("pend_busy", 64'(busy), 64'd1);
        check("pend_rs1", 64'(rs1), 64'd0);
        step();
        check("pend_ready", 64'(ready), 64'd1);
        check("pend_retired0", retired, 64'd0);
        step();
        check("pend_retired1", retired, 64'd1);
        check("pend_x9", 64'(rs1), 64'h55);

        // Reset on an accept edge.
        din.inst_rd = 5'd10;
        din.rd      = 32'h77;
        din.strobe  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) step();
        check("race_ready", 64'(ready), 64'd1);
        check("race_retired", retired, 64'd0);
        for (int i = 0; i < 32; i++) begin
            rs1i = 5'(i);
            #1;
            check("sweep_zero", 64'(rs1), 64'd0);
        end
        rs1i = 5'd10;
        commit(5'd10, 32'h77);
        check("race_after_x10", 64'(rs1), 64'h77);
        check("race_after_ret", retired, 64'd1);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_writeback.md
# cpu_writeback

Final pipeline stage of the RV32 core, directly downstream of the memory stage. Consumes the memory stage's `memory_data_t` output through the strobe-toggle handshake and commits the result into the architectural register file. Serves the decode stage's two register read ports with same-cycle write bypass, and counts retired instructions. After reset it clears the register file with a one-entry-per-cycle sweep state machine.

## Interface
Parameters:
- `REGISTER_COUNT`, default 32: number of architectural registers. Legal values are 32 (RV32I) or 16 (RV32E).

Ports:
- `i_clock`  in  1  core clock.
- `i_reset`  in  1  reset. One clock; reset is synchronous and active-high.
- `i_data`  in  `memory_data_t`  memory stage result: `rd[31:0]`, `inst_rd[4:0]`, `strobe`.
- `o_busy`  out  1  stage cannot accept this cycle.
- `o_ready`  out  1  register file sweep is complete; core may start fetching.
- `i_rs1_index`  in  5  decode read port 1 index.
- `o_rs1`  out  32  read data for port 1.
- `i_rs2_index`  in  5  decode read port 2 index.
- `o_rs2`  out  32  read data for port 2.
- `o_data`  out  `writeback_data_t`  last committed `inst_rd[4:0]`, `rd[31:0]`, `strobe`. Used by decode hazard logic.
- `o_retired`  out  64  retired instruction count.

## Operation
- **State machine:** `CLEAR` → `RUN`.
  - Reset forces `CLEAR` and `clear_index=0`.
  - `CLEAR` writes 0 to `regs[clear_index]` each cycle and increments the index. After writing index `REGISTER_COUNT-1` it moves to `RUN`.
  - `RUN` is held until the next reset. An illegal state returns to `CLEAR`.
- **Accept condition:** `state==RUN` and `i_data.strobe != last_strobe`. On accept:
  - `last_strobe <= i_data.strobe`.
  - If `inst_rd != 0` and `inst_rd < REGISTER_COUNT`: `regs[inst_rd] <= rd`.
  - `o_data.inst_rd/rd` are loaded from `i_data`, and `o_data.strobe` toggles.
  - `o_retired` increments by 1, wrapping modulo 2^64.
- **Writes to x0:** commit with no register write, but still toggle the strobe and still count.
- **Out-of-range index (RV32E, `inst_rd >= REGISTER_COUNT`):** treated exactly like a write to x0.
- **Busy:** `o_busy = (state==CLEAR)`. In `CLEAR`, a strobe toggle is left pending and is accepted on the first `RUN` cycle. The memory stage holds `i_data` stable until `o_data.strobe` toggles.
- **Read ports** (combinational), for each port:
  - Index 0 or index ≥ `REGISTER_COUNT` → 0.
  - Else, if an accept is occurring this cycle with a matching nonzero `inst_rd` → `i_data.rd` (bypass).
  - Else → `regs[index]`.
  - During `CLEAR`, reads return 0.
- **Reset mid-commit:** reset wins. No write, no count, and `last_strobe` is cleared.

## Timing
Reset values (all outputs are registered or derived from reset state):
- `o_busy=1`, `o_ready=0`, `o_data=0`, `o_retired=0`, `last_strobe=0`.
- `o_rs1`/`o_rs2` read 0.

Latency and throughput:
- `o_ready` rises exactly `REGISTER_COUNT` cycles after the reset cycle is released.
- Commit latency is one clock. The write, the `o_data` update, the strobe toggle and the count increment all land on the accepting edge.
- A read issued in the cycle after commit sees the array value. A read in the accept cycle sees the bypass.
- Throughput is one commit per cycle, since the memory stage can toggle its strobe every cycle.

## Structure
- `memory_data_t` and `writeback_data_t` live in the shared `CPU_Types` package next to `execute_data_t`.
- Register-file width and x0 constants go in `CPU_Defines.sv`.
- Natural sub-module: `CPU_Registers`, the register array with two async read ports, one sync write port and the bypass mux.
- The FSM, handshake and retire counter stay in `cpu_writeback`.

## Test plan
- **Reset sweep:** pre-load garbage via a backdoor, assert `i_reset` for 1 cycle → `o_busy=1` for 32 cycles, then `o_ready=1`; every read returns 0.
- **Basic commit:** `inst_rd=5`, `rd=0xDEADBEEF`, toggle strobe → next cycle `o_rs1` with index 5 reads `0xDEADBEEF`, `o_data.strobe` toggled, `o_retired=1`.
- **x0 commit:** `inst_rd=0`, `rd=0x12345678` → x0 still reads 0, strobe toggles, `o_retired` increments.
- **Bypass:** in the accept cycle of `inst_rd=7`, `rd=0xA5A5A5A5`, drive `i_rs2_index=7` → `o_rs2=0xA5A5A5A5` in the same cycle, while `o_rs1` (index 8) shows the old value.
- **Back-to-back:** 4 consecutive toggles writing x1..x4 = 1..4 → all four registers hold their values, `o_retired=4`, four `o_data` strobe toggles.
- **Strobe during CLEAR:** toggle strobe in cycle 3 after reset with `inst_rd=9`, `rd=0x55` → accepted in the first `RUN` cycle, x9 = `0x55`, `o_retired=1`. Variant: assert reset on an accept edge → no write, `o_retired=0`.
